round_robin_dispatcher: RTL and testbench
=========================================

Name: round_robin_dispatcher

Overview:
Splits one valid/ready flit stream across NUM_OUT output lanes, one whole packet per lane, choosing lanes in round-robin order. It is the distribution-side counterpart of the NoC round-robin arbiter. It sits at the NoC ejection point and feeds parallel consumer queues. Each lane has a one-entry output register. A packet is never split across lanes.

Parameters:
NUM_OUT, 4, number of output lanes (2..16, any integer, not limited to powers of 2)
DATA_W, 32, flit payload width in bits
PTR_W, $clog2(NUM_OUT), width of the round-robin pointer (derived; not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  input flit valid
in_ready  output  1  input flit accepted when in_valid && in_ready
in_data  input  DATA_W  input flit payload
in_last  input  1  final flit of the packet
out_enable  input  NUM_OUT  per-lane eligibility mask for new packets
out_valid  output  NUM_OUT  per-lane output register valid
out_ready  input  NUM_OUT  per-lane consumer ready
out_data  output  NUM_OUT*DATA_W  lane i data in bits [i*DATA_W +: DATA_W]
out_last  output  NUM_OUT  per-lane last flag
pkt_count  output  16  count of completed packets dispatched; wraps

Behaviour:
- Reset (async, rst_n low):
  - ptr=0, state=IDLE, lock_idx=0.
  - out_valid=0, out_data=0, out_last=0, pkt_count=0.
  - in_ready=0 while rst_n is low.
- Lane free: lane i is free when !out_valid[i] || out_ready[i]. A lane may drain and reload in the same cycle.
- Lane register hold: while out_valid[i] && !out_ready[i], lane i data/last are held stable.
- Lane register drain: on out_ready[i] with no new load, out_valid[i] clears.
- State IDLE (at a packet boundary):
  - Target = first lane j, searching circularly from ptr through ptr+NUM_OUT-1 mod NUM_OUT, with out_enable[j] && free[j].
  - in_ready=1 iff such a target exists.
  - Target selection is combinational, so the target can change cycle to cycle until a flit is accepted.
- State LOCKED (mid-packet):
  - Target = lock_idx.
  - in_ready = free[lock_idx].
  - out_enable[lock_idx] is ignored until the packet ends.
- On flit acceptance:
  - Load the target lane: out_valid=1, out_data=in_data, out_last=in_last.
  - Latency from acceptance to out_valid is exactly 1 cycle.
- State transitions:
  - IDLE, accepted flit with in_last=0 → LOCKED, lock_idx=target.
  - IDLE, accepted flit with in_last=1 (single-flit packet) → stay IDLE, ptr=(target+1) mod NUM_OUT, pkt_count+1.
  - LOCKED, accepted flit with in_last=1 → IDLE, ptr=(lock_idx+1) mod NUM_OUT, pkt_count+1.
  - LOCKED, accepted flit with in_last=0 → stay LOCKED.
- ptr changes only on packet completion, never on head acceptance or stalls.
- ptr wraps from NUM_OUT-1 to 0, including for non-power-of-2 NUM_OUT.
- No eligible lane (all disabled or all full in IDLE): in_ready=0 and nothing changes.
- out_enable all zero mid-packet: the packet still completes on lock_idx.
- pkt_count is 16-bit and wraps 0xFFFF→0x0000.
- in_valid low: no state change except lane drains.
- Reset mid-packet: all state clears immediately. The partial packet is dropped. The first flit after reset is treated as a head.

Test Plan:
- Single-flit packets A,B,C,D,E, all lanes enabled and ready → appear on lanes 0,1,2,3,0, each 1 cycle after acceptance; pkt_count=5; in_ready constant 1.
- 3-flit packet (last on flit 3), then 1-flit packet → all 3 flits on lane 0 in order; next packet on lane 1; ptr=2 afterwards.
- out_enable=4'b1010 from reset → packets go to lanes 1,3,1,3.
- Lane 1 out_ready=0 with lane 1 already full, ptr=1 → next packet goes to lane 2, and lane 1 holds its data stable.
- All lanes full and stalled → in_ready=0. Release lane 2 → in_ready=1 and the packet lands on lane 2.
- Mid-packet on lane 0:
  - Drop out_enable[0] → remaining flits still go to lane 0.
  - Then hold out_ready[0]=0 for 3 cycles → in_ready=0 for those cycles, with no flit loss or duplication.
- Pulse rst_n low mid-packet → all out_valid=0, ptr=0, pkt_count=0; the next flit lands on lane 0 as a head.
- Send 65537 single-flit packets → pkt_count=1.

Source files
------------

// File: rtl/round_robin_dispatcher.sv
// Deals whole packets from one flit stream onto NUM_OUT lanes in round-robin order; 1-cycle accept-to-out_valid.
// Backpressure: in_ready drops when no enabled lane is free (idle) or the locked lane is still full (mid-packet).
module round_robin_dispatcher #(
    parameter int  NUM_OUT = 4,
    parameter int  DATA_W  = 32,
    localparam int PTR_W   = $clog2(NUM_OUT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_last,
    input  logic [NUM_OUT-1:0]        out_enable,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_last,
    output logic [15:0]               pkt_count
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                    state_q, state_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [PTR_W-1:0]          lock_idx_q, lock_idx_d;
    logic [NUM_OUT-1:0]        out_valid_q, out_valid_d;
    logic [NUM_OUT*DATA_W-1:0] out_data_q, out_data_d;
    logic [NUM_OUT-1:0]        out_last_q, out_last_d;
    logic [15:0]               pkt_count_q, pkt_count_d;

    logic [NUM_OUT-1:0] lane_free;
    logic               found;
    logic [PTR_W-1:0]   srch_idx;
    logic [PTR_W-1:0]   tgt;
    logic               accept;

    always_comb begin
        int idx;
        idx       = 0;
        lane_free = ~out_valid_q | out_ready;
        found     = 1'b0;
        srch_idx  = '0;
        // Circular search starting at ptr; modulo done by subtraction so any NUM_OUT works.
        for (int k = 0; k < NUM_OUT; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_OUT) idx = idx - NUM_OUT;
            if (!found && out_enable[idx] && lane_free[idx]) begin
                found    = 1'b1;
                srch_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_idx_d  = lock_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        pkt_count_d = pkt_count_q;

        tgt      = (state_q == LOCKED) ? lock_idx_q : srch_idx;
        in_ready = rst_n && ((state_q == LOCKED) ? lane_free[lock_idx_q] : found);
        accept   = in_valid && in_ready;

        for (int i = 0; i < NUM_OUT; i++) begin
            if (out_ready[i]) out_valid_d[i] = 1'b0;
        end

        // A load overrides the drain, so a lane can empty and refill in one cycle.
        if (accept) begin
            out_valid_d[tgt]                  = 1'b1;
            out_data_d[tgt*DATA_W +: DATA_W]  = in_data;
            out_last_d[tgt]                   = in_last;
            if (in_last) begin
                state_d     = IDLE;
                ptr_d       = (tgt == PTR_W'(NUM_OUT-1)) ? '0 : tgt + 1'b1;
                pkt_count_d = pkt_count_q + 16'd1;
            end else begin
                state_d    = LOCKED;
                lock_idx_d = tgt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            lock_idx_q  <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_idx_q  <= lock_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_round_robin_dispatcher.sv
// Directed bench for round_robin_dispatcher with per-lane expected-flit queues.
module tb_round_robin_dispatcher;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           in_last = 1'b0;
    logic [N-1:0]   out_enable = '1;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready = '1;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_last;
    logic [15:0]    pkt_count;

    typedef logic [W:0] item_t;
    item_t expq [N][$];

    int total = 0;
    int bad   = 0;

    round_robin_dispatcher #(.NUM_OUT(N), .DATA_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_enable (out_enable),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop and compare every flit the consumer takes at the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    total++;
                    assert (expq[i].size() > 0) else begin
                        bad++;
                        $error("FAIL lane%0d_unexpected observed=%0h expected=none", i, out_data[i*W +: W]);
                    end
                    if (expq[i].size() > 0) begin
                        item_t e;
                        e = expq[i].pop_front();
                        chk($sformatf("lane%0d_flit", i), {31'd0, out_last[i], out_data[i*W +: W]}, {31'd0, e});
                    end
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic l, input int lane, output int waited);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (waited = 0; waited < 20; waited++) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
        end
        if (waited >= 20) begin
            chk("send_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            expq[lane].push_back({l, d});
            @(posedge clk);
            #1;
            chk($sformatf("lat_vld_lane%0d", lane), 64'(out_valid[lane]), 64'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic send1(input logic [W-1:0] d, input logic l, input int lane);
        int w;
        send(d, l, lane, w);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) expq[i].delete();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data[63:0]), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int w;
        // Reset values while held in reset from time 0.
        #2;
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_in_ready", 64'(in_ready), 64'd0);
        chk("init_pkt_count", 64'(pkt_count), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Single-flit packets A..E rotate 0,1,2,3,0 without stalls.
        for (int i = 0; i < 5; i++) begin
            send(32'hA000_0000 + i, 1'b1, i % N, w);
            chk("rr_no_stall", 64'(w), 64'd0);
        end
        chk("pkt_count_5", 64'(pkt_count), 64'd5);

        // 3-flit packet stays on lane 0, next packet lane 1, then ptr=2.
        apply_reset();
        send1(32'hB000_0001, 1'b0, 0);
        send1(32'hB000_0002, 1'b0, 0);
        send1(32'hB000_0003, 1'b1, 0);
        send1(32'hB000_0004, 1'b1, 1);
        send1(32'hB000_0005, 1'b1, 2);
        chk("pkt_count_3", 64'(pkt_count), 64'd3);

        // Only lanes 1 and 3 enabled.
        apply_reset();
        out_enable = 4'b1010;
        send1(32'hC000_0001, 1'b1, 1);
        send1(32'hC000_0002, 1'b1, 3);
        send1(32'hC000_0003, 1'b1, 1);
        send1(32'hC000_0004, 1'b1, 3);
        out_enable = 4'b1111;

        // Lane 1 stalled and full with ptr=1: next packet skips to lane 2.
        apply_reset();
        out_ready = 4'b1101;
        send1(32'hD000_0000, 1'b1, 0);
        send1(32'hD000_0001, 1'b1, 1);
        send1(32'hD000_0002, 1'b1, 2);
        send1(32'hD000_0003, 1'b1, 3);
        send1(32'hD000_0004, 1'b1, 0);
        send1(32'hD000_0005, 1'b1, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_vld1", 64'(out_valid[1]), 64'd1);
            chk("hold_dat1", 64'(out_data[1*W +: W]), 64'hD000_0001);
        end
        @(posedge clk); #1; out_ready = 4'b1111;
        repeat (2) @(posedge clk);
        #1;

        // All lanes full and stalled, then lane 2 released.
        apply_reset();
        out_ready = 4'b0000;
        for (int i = 0; i < N; i++) send1(32'hE000_0000 + i, 1'b1, i);
        in_valid = 1'b1; in_data = 32'hE000_00FF; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("all_full_rdy", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1; out_ready = 4'b0100;
        send1(32'hE000_00FF, 1'b1, 2);
        @(posedge clk); #1; out_ready = 4'b1111;
        repeat (2) @(posedge clk);
        #1;

        // Mid-packet on lane 0: enable dropped, then lane 0 stalled.
        apply_reset();
        send1(32'hF000_0001, 1'b0, 0);
        out_enable = 4'b1110;
        send1(32'hF000_0002, 1'b0, 0);
        out_ready = 4'b1110;
        in_valid = 1'b1; in_data = 32'hF000_0003; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("locked_stall_rdy", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1; out_ready = 4'b1111;
        send1(32'hF000_0003, 1'b1, 0);
        out_enable = 4'b1111;
        chk("pkt_count_locked", 64'(pkt_count), 64'd1);

        // Reset mid-packet on lane 1; next flit is a head on lane 0.
        send1(32'h1100_0001, 1'b0, 1);
        apply_reset();
        send1(32'h1100_0002, 1'b1, 0);
        send1(32'h1100_0003, 1'b1, 1);
        chk("pkt_count_after_rst", 64'(pkt_count), 64'd2);

        // pkt_count wraps after 65536 packets.
        apply_reset();
        for (int i = 0; i < 65537; i++) send1(32'h2000_0000 + i, 1'b1, i % N);
        chk("pkt_count_wrap", 64'(pkt_count), 64'd1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) chk($sformatf("q_empty%0d", i), 64'(expq[i].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
